// File: rtl/simple_pkg.sv
// Shared encodings for the multi-cycle sequencer: phases, states, opcode classes,
// ALU function codes, branch conditions and condition-code bit positions.
package simple_pkg;

    localparam int PHASE_W = 5;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t P1 = 5'b00001;
    localparam phase_t P2 = 5'b00010;
    localparam phase_t P3 = 5'b00100;
    localparam phase_t P4 = 5'b01000;
    localparam phase_t P5 = 5'b10000;

    typedef enum logic [2:0] {
        ST_HALT, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5
    } state_t;

    // instr[15:14]
    localparam logic [1:0] CL_LD  = 2'b00;
    localparam logic [1:0] CL_ST  = 2'b01;
    localparam logic [1:0] CL_BR  = 2'b10;
    localparam logic [1:0] CL_ALU = 2'b11;

    // instr[15:11] for the non-ALU immediate/branch group
    localparam logic [4:0] OP5_LI = 5'b10000;
    localparam logic [4:0] OP5_B  = 5'b10100;
    localparam logic [4:0] OP5_BC = 5'b10111;

    // op3 = instr[7:4]
    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_OR  = 4'h3;
    localparam logic [3:0] F_XOR = 4'h4;
    localparam logic [3:0] F_CMP = 4'h5;
    localparam logic [3:0] F_MOV = 4'h6;
    localparam logic [3:0] F_HLT = 4'hF;

    localparam logic [2:0] C_BE  = 3'b000;
    localparam logic [2:0] C_BLT = 3'b001;
    localparam logic [2:0] C_BLE = 3'b010;
    localparam logic [2:0] C_BNE = 3'b011;

    localparam int S = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    function automatic logic is_known_alu(input logic [3:0] op3);
        return (op3 <= F_MOV);
    endfunction

endpackage

// File: rtl/simple_br_cond.sv
// Conditional-branch evaluator: maps a 3-bit condition and {S,Z,C,V} to taken.
// Purely combinational; reserved condition codes are never taken.
module simple_br_cond
    import simple_pkg::*;
(
    input  logic [3:0] cc,
    input  logic [2:0] cond,
    output logic       taken
);

    logic lt;
    logic unused_carry;

    assign lt           = cc[S] ^ cc[V];
    assign unused_carry = cc[C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            C_BE:    taken = cc[Z];
            C_BLT:   taken = lt;
            C_BLE:   taken = cc[Z] | lt;
            C_BNE:   taken = ~cc[Z];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/simple_seq_ctrl.sv
// Five-phase instruction sequencer (fetch/decode/execute/memory/writeback) with CC register.
// Latency: 5 cycles per instruction, 5+MEM_WAIT for LD/ST; stalls only in P4.
// No backpressure input; SEQ_SINGLE_STEP_EN adds a step port to run one instruction from HALT.
module simple_seq_ctrl
    import simple_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int PW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic [15:0]   instr,
    input  logic [3:0]    alu_code,
    output logic [PW-1:0] phase,
    output logic          ir_we,
    output logic          pc_we,
    output logic          pc_sel_br,
    output logic          cc_we,
    output logic [3:0]    cc,
    output logic          reg_we,
    output logic          mem_re,
    output logic          mem_we,
    output logic          halted
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q;
    logic [3:0] cc_q;
    phase_t     phase_c;

    logic [1:0] cls;
    logic [3:0] op3;
    logic [4:0] op5;
    logic       is_ld, is_st, is_alu, is_hlt;
    logic       cc_op, wb_op, cond_taken, br_taken;
    logic       stop_after;
    logic       unused_bits;

    assign cls = instr[15:14];
    assign op3 = instr[7:4];
    assign op5 = instr[15:11];
    assign unused_bits = ^instr[3:0];

    assign is_ld  = (cls == CL_LD);
    assign is_st  = (cls == CL_ST);
    assign is_alu = (cls == CL_ALU);
    assign is_hlt = is_alu && (op3 == F_HLT);
    // MOV and CMP both refresh flags; only CMP skips the register write.
    assign cc_op  = is_alu && is_known_alu(op3);
    assign wb_op  = (cc_op && (op3 != F_CMP)) || is_ld || (op5 == OP5_LI);

    simple_br_cond u_br_cond (
        .cc    (cc_q),
        .cond  (instr[10:8]),
        .taken (cond_taken)
    );

    assign br_taken = (op5 == OP5_B) || ((op5 == OP5_BC) && cond_taken);

`ifdef SEQ_SINGLE_STEP_EN
    logic single_q;

    always_ff @(posedge clk) begin
        if (rst)
            single_q <= 1'b0;
        else if (state_q == ST_HALT && state_d == ST_P1)
            single_q <= ~run;
    end

    assign stop_after = single_q;
`else
    assign stop_after = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_c   = '0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel_br = 1'b0;
        cc_we     = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run)
                    state_d = ST_P1;
`ifdef SEQ_SINGLE_STEP_EN
                else if (step)
                    state_d = ST_P1;
`endif
            end
            ST_P1: begin
                phase_c = P1;
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_P2;
            end
            ST_P2: begin
                phase_c = P2;
                state_d = ST_P3;
            end
            ST_P3: begin
                phase_c = P3;
                cc_we   = cc_op;
                state_d = ST_P4;
            end
            ST_P4: begin
                phase_c = P4;
                mem_re  = is_ld;
                if (wait_q == 4'd0) begin
                    mem_we    = is_st;
                    pc_we     = br_taken;
                    pc_sel_br = br_taken;
                    state_d   = ST_P5;
                end
            end
            ST_P5: begin
                phase_c = P5;
                reg_we  = wb_op;
                state_d = (is_hlt || stop_after) ? ST_HALT : ST_P1;
            end
            default: state_d = ST_HALT;
        endcase
        // Reset must not leak a write into the datapath on the same edge.
        if (rst) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel_br = 1'b0;
            cc_we     = 1'b0;
            reg_we    = 1'b0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            wait_q  <= 4'd0;
            cc_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (cc_we)
                cc_q <= alu_code;
            if (state_q == ST_P3)
                wait_q <= (is_ld || is_st) ? WAIT_INIT : 4'd0;
            else if (state_q == ST_P4 && wait_q != 4'd0)
                wait_q <= wait_q - 4'd1;
        end
    end

    assign phase  = phase_c;
    assign cc     = cc_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_simple_seq_ctrl.sv
// Directed bench for simple_seq_ctrl (MEM_WAIT=3): per-instruction strobe profiles
// are recorded cycle by cycle and compared against hand-derived expectations.
module tb_simple_seq_ctrl;
    import simple_pkg::*;

    localparam logic [15:0] I_ADD = 16'hC000;
    localparam logic [15:0] I_CMP = 16'hC050;
    localparam logic [15:0] I_UNK = 16'hC080;
    localparam logic [15:0] I_HLT = 16'hC0F0;
    localparam logic [15:0] I_LI  = 16'h8000;
    localparam logic [15:0] I_B   = 16'hA000;
    localparam logic [15:0] I_BE  = 16'hB800;
    localparam logic [15:0] I_BLT = 16'hB900;
    localparam logic [15:0] I_BLE = 16'hBA00;
    localparam logic [15:0] I_BNE = 16'hBB00;
    localparam logic [15:0] I_BRV = 16'hBC00;
    localparam logic [15:0] I_LD  = 16'h0000;
    localparam logic [15:0] I_ST  = 16'h4000;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [15:0] instr;
    logic [3:0]  alu_code;
    logic [4:0]  phase;
    logic        ir_we, pc_we, pc_sel_br, cc_we, reg_we, mem_re, mem_we, halted;
    logic [3:0]  cc;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // per-instruction record
    int         r_cyc, r_p4, r_reg, r_ccwe, r_mre, r_mwe, r_mwe_idx, r_br, r_sel, r_pcwe, r_ir;
    logic [4:0] r_reg_ph, r_br_ph, r_end_ph;
    logic       r_end_halt;

    always #5 clk = ~clk;

    simple_seq_ctrl #(.MEM_WAIT(3), .PW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (step),
`endif
        .instr     (instr),
        .alu_code  (alu_code),
        .phase     (phase),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel_br (pc_sel_br),
        .cc_we     (cc_we),
        .cc        (cc),
        .reg_we    (reg_we),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .halted    (halted)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drives one instruction from P1 until the next P1 or HALT, with a cycle budget.
    task automatic run_one(input logic [15:0] ins, input logic [3:0] ac);
        instr = ins; alu_code = ac;
        r_cyc = 0; r_p4 = 0; r_reg = 0; r_ccwe = 0; r_mre = 0; r_mwe = 0; r_mwe_idx = 0;
        r_br = 0; r_sel = 0; r_pcwe = 0; r_ir = 0; r_reg_ph = '0; r_br_ph = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            r_cyc++;
            if (phase == P4) r_p4++;
            if (reg_we) begin r_reg++; r_reg_ph = phase; end
            if (cc_we) r_ccwe++;
            if (mem_re) r_mre++;
            if (mem_we) begin r_mwe++; r_mwe_idx = r_p4; end
            if (pc_we && pc_sel_br) begin r_br++; r_br_ph = phase; end
            if (pc_sel_br) r_sel++;
            if (pc_we) r_pcwe++;
            if (ir_we) r_ir++;
            tick();
            if (phase == P1 || halted) break;
        end
        r_end_ph = phase; r_end_halt = halted;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; instr = I_ADD; alu_code = 4'b0000;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        n_chk++; if (phase !== 5'b0) $display("FAIL rst_phase got %b want 00000", phase); else n_pass++;
        n_chk++; if (halted !== 1'b1) $display("FAIL rst_halted got %b want 1", halted); else n_pass++;
        n_chk++; if (cc !== 4'b0) $display("FAIL rst_cc got %b want 0000", cc); else n_pass++;
        n_chk++; if ({ir_we, pc_we, reg_we, mem_re, mem_we, cc_we} !== 6'b0)
            $display("FAIL rst_strobes got %b want 000000", {ir_we, pc_we, reg_we, mem_re, mem_we, cc_we}); else n_pass++;
        tick(); tick();
        n_chk++; if (halted !== 1'b1) $display("FAIL idle_halted got %b want 1", halted); else n_pass++;
        run = 1'b1; tick(); run = 1'b0;
        #1;
        n_chk++; if (phase !== P1) $display("FAIL run_p1 got %b want %b", phase, P1); else n_pass++;
        n_chk++; if ({ir_we, pc_we, pc_sel_br} !== 3'b110) $display("FAIL p1_strobes got %b want 110", {ir_we, pc_we, pc_sel_br}); else n_pass++;
        // abort an ADD in P3
        instr = I_ADD; alu_code = 4'b0100;
        tick(); tick();
        #1;
        n_chk++; if (phase !== P3 || cc_we !== 1'b1) $display("FAIL p3_ccwe got %b/%b want %b/1", phase, cc_we, P3); else n_pass++;
        rst = 1'b1; alu_code = 4'b1111;
        #1;
        n_chk++; if (cc_we !== 1'b0 || reg_we !== 1'b0) $display("FAIL rst_cycle_strobes got %b%b want 00", cc_we, reg_we); else n_pass++;
        tick(); rst = 1'b0;
        #1;
        n_chk++; if ({phase, halted, cc} !== {5'b0, 1'b1, 4'b0})
            $display("FAIL midp3_reset got %b/%b/%b want 00000/1/0000", phase, halted, cc); else n_pass++;
    endtask

    task automatic test_alu();
        run = 1'b1; tick(); run = 1'b0;
        run_one(I_ADD, 4'b0100);
        n_chk++; if (r_cyc !== 5) $display("FAIL add_cycles got %0d want 5", r_cyc); else n_pass++;
        n_chk++; if (cc !== 4'b0100) $display("FAIL add_cc got %b want 0100", cc); else n_pass++;
        n_chk++; if (r_reg !== 1 || r_reg_ph !== P5) $display("FAIL add_regwe got %0d@%b want 1@%b", r_reg, r_reg_ph, P5); else n_pass++;
        n_chk++; if (r_ir !== 1 || r_pcwe !== 1 || r_ccwe !== 1) $display("FAIL add_strobes got ir%0d pc%0d cc%0d want 1 1 1", r_ir, r_pcwe, r_ccwe); else n_pass++;
        n_chk++; if (r_end_ph !== P1) $display("FAIL add_next got %b want %b", r_end_ph, P1); else n_pass++;
        run_one(I_UNK, 4'b1111);
        n_chk++; if (r_reg !== 0 || r_ccwe !== 0 || cc !== 4'b0100) $display("FAIL nop_op got reg%0d ccwe%0d cc%b want 0 0 0100", r_reg, r_ccwe, cc); else n_pass++;
        run_one(I_LI, 4'b1111);
        n_chk++; if (r_reg !== 1 || r_ccwe !== 0 || r_cyc !== 5) $display("FAIL li got reg%0d ccwe%0d cyc%0d want 1 0 5", r_reg, r_ccwe, r_cyc); else n_pass++;
    endtask

    task automatic test_branch();
        run_one(I_CMP, 4'b1001);
        n_chk++; if (cc !== 4'b1001 || r_reg !== 0) $display("FAIL cmp got cc%b reg%0d want 1001 0", cc, r_reg); else n_pass++;
        run_one(I_BLT, 4'b0000);
        n_chk++; if (r_br !== 0 || r_sel !== 0 || r_pcwe !== 1) $display("FAIL blt_nt got br%0d sel%0d pcwe%0d want 0 0 1", r_br, r_sel, r_pcwe); else n_pass++;
        n_chk++; if (cc !== 4'b1001) $display("FAIL br_keeps_cc got %b want 1001", cc); else n_pass++;
        run_one(I_CMP, 4'b1000);
        run_one(I_BLT, 4'b0000);
        n_chk++; if (r_br !== 1 || r_br_ph !== P4 || r_sel !== 1) $display("FAIL blt_t got br%0d@%b sel%0d want 1@%b 1", r_br, r_br_ph, r_sel, P4); else n_pass++;
        n_chk++; if (r_cyc !== 5 || r_reg !== 0) $display("FAIL blt_shape got cyc%0d reg%0d want 5 0", r_cyc, r_reg); else n_pass++;
        run_one(I_BE, 4'b0000);
        n_chk++; if (r_br !== 0) $display("FAIL be_nt got %0d want 0", r_br); else n_pass++;
        run_one(I_BNE, 4'b0000);
        n_chk++; if (r_br !== 1) $display("FAIL bne_t got %0d want 1", r_br); else n_pass++;
        run_one(I_CMP, 4'b0100);
        run_one(I_BLE, 4'b0000);
        n_chk++; if (r_br !== 1) $display("FAIL ble_z got %0d want 1", r_br); else n_pass++;
        run_one(I_BRV, 4'b0000);
        n_chk++; if (r_br !== 0) $display("FAIL cond_rsvd got %0d want 0", r_br); else n_pass++;
        run_one(I_B, 4'b0000);
        n_chk++; if (r_br !== 1 || r_pcwe !== 2) $display("FAIL b_always got br%0d pcwe%0d want 1 2", r_br, r_pcwe); else n_pass++;
    endtask

    task automatic test_mem();
        run_one(I_ST, 4'b0000);
        n_chk++; if (r_cyc !== 8 || r_p4 !== 4) $display("FAIL st_len got cyc%0d p4%0d want 8 4", r_cyc, r_p4); else n_pass++;
        n_chk++; if (r_mwe !== 1 || r_mwe_idx !== 4) $display("FAIL st_memwe got %0d@%0d want 1@4", r_mwe, r_mwe_idx); else n_pass++;
        n_chk++; if (r_reg !== 0 || r_mre !== 0) $display("FAIL st_other got reg%0d mre%0d want 0 0", r_reg, r_mre); else n_pass++;
        run_one(I_LD, 4'b0000);
        n_chk++; if (r_mre !== 4 || r_mwe !== 0 || r_cyc !== 8) $display("FAIL ld_mem got mre%0d mwe%0d cyc%0d want 4 0 8", r_mre, r_mwe, r_cyc); else n_pass++;
        n_chk++; if (r_reg !== 1 || r_reg_ph !== P5) $display("FAIL ld_regwe got %0d@%b want 1@%b", r_reg, r_reg_ph, P5); else n_pass++;
        run_one(I_ADD, 4'b0001);
        n_chk++; if (r_cyc !== 5 || r_p4 !== 1) $display("FAIL alu_no_wait got cyc%0d p4%0d want 5 1", r_cyc, r_p4); else n_pass++;
    endtask

    task automatic test_hlt();
        run_one(I_HLT, 4'b1111);
        n_chk++; if (r_end_halt !== 1'b1 || r_end_ph !== 5'b0) $display("FAIL hlt_end got %b/%b want 1/00000", r_end_halt, r_end_ph); else n_pass++;
        n_chk++; if (r_cyc !== 5 || r_reg !== 0 || r_ccwe !== 0) $display("FAIL hlt_shape got cyc%0d reg%0d ccwe%0d want 5 0 0", r_cyc, r_reg, r_ccwe); else n_pass++;
        tick(); tick();
        n_chk++; if (halted !== 1'b1) $display("FAIL hlt_stays got %b want 1", halted); else n_pass++;
        run = 1'b1; rst = 1'b1; tick(); run = 1'b0; rst = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b1 || phase !== 5'b0) $display("FAIL run_rst got %b/%b want 1/00000", halted, phase); else n_pass++;
        run = 1'b1; tick(); run = 1'b0;
        #1;
        n_chk++; if (phase !== P1) $display("FAIL restart got %b want %b", phase, P1); else n_pass++;
        run = 1'b1;
        run_one(I_ADD, 4'b0000);
        run = 1'b0;
        n_chk++; if (r_cyc !== 5 || r_end_ph !== P1) $display("FAIL run_ignored got cyc%0d end%b want 5 %b", r_cyc, r_end_ph, P1); else n_pass++;
        run_one(I_HLT, 4'b0000);
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_step();
        step = 1'b1; tick(); step = 1'b0;
        #1;
        n_chk++; if (phase !== P1) $display("FAIL step_start got %b want %b", phase, P1); else n_pass++;
        run_one(I_ADD, 4'b0000);
        n_chk++; if (r_cyc !== 5 || r_end_halt !== 1'b1) $display("FAIL step_one got cyc%0d halt%b want 5 1", r_cyc, r_end_halt); else n_pass++;
        run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
        run_one(I_ADD, 4'b0000);
        n_chk++; if (r_end_ph !== P1 || r_end_halt !== 1'b0) $display("FAIL run_over_step got %b/%b want %b/0", r_end_ph, r_end_halt, P1); else n_pass++;
        run_one(I_HLT, 4'b0000);
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_hlt();
`ifdef SEQ_SINGLE_STEP_EN
        test_step();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/simple_seq_ctrl.md
Name: simple_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit CPU. It steps each instruction through five phases: P1 fetch, P2 decode/register read, P3 ALU execute, P4 memory, P5 writeback.
- Owns the condition-code register {S,Z,C,V}, which captures the ALU code output.
- Decides taken/not-taken for B/BE/BLT/BLE/BNE.
- Drives every write enable in the datapath: IR, PC, register file, data memory, CC.

Parameters:
- MEM_WAIT, default 0: extra stall cycles spent in P4 for LD/ST (0..15).
- PW, default 5: phase-vector width. Fixed at 5; present only for the package typedef.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  start pulse; leaves HALT
- instr  in  16  IR contents, valid from P2 onward
- alu_code  in  4  ALU {s,z,c,v}, valid in P3
- phase  out  5  one-hot {P5,P4,P3,P2,P1}; all-zero in HALT
- ir_we  out  1  load IR from memory
- pc_we  out  1  update PC
- pc_sel_br  out  1  1 = PC <- ALU result (branch target); 0 = PC+1
- cc_we  out  1  CC register capture strobe (observability)
- cc  out  4  registered {S,Z,C,V}
- reg_we  out  1  register-file write
- mem_re  out  1  data-memory read (LD)
- mem_we  out  1  data-memory write (ST)
- halted  out  1  1 in HALT state

Behaviour:
- Reset and initial state:
  - Synchronous and active-high.
  - Reset: state=HALT, phase=0, cc=4'b0000, halted=1, wait counter=0, all strobes 0.
  - rst wins over every other input in the same cycle, including mid-instruction; no write strobe is issued in the reset cycle.
- States: HALT, P1, P2, P3, P4, P5.
  - HALT: halted=1. run=1 → P1 next cycle.
  - P1: ir_we=1, pc_we=1, pc_sel_br=0 (PC+1). → P2.
  - P2: no strobes. → P3.
  - P3: → P4. If instr[15:14]=2'b11 and op3=instr[7:4] ∈ {ADD,SUB,AND,OR,XOR,CMP,MOV}, then cc_we=1 and cc<=alu_code at the clock edge.
  - P4: see wait rule and memory strobes below.
  - P5: → P1 unless HLT, in which case → HALT.
- P4 wait rule (LD = instr[15:14]=2'b00; ST = 2'b01):
  - Counter loads MEM_WAIT on entry to P4.
  - Stay in P4 while the counter is non-zero, decrementing each cycle.
  - Non-memory instructions and MEM_WAIT=0: exactly one P4 cycle.
- Memory strobes:
  - mem_re is held for every P4 cycle of LD.
  - mem_we is asserted only in the final P4 cycle of ST, so it is a single pulse.
- Branches, evaluated in P4 using registered cc:
  - B (instr[15:11]=5'b10100): always taken.
  - Conditional (5'b10111), cond=instr[10:8]:
    - 000 BE: Z
    - 001 BLT: S^V
    - 010 BLE: Z|(S^V)
    - 011 BNE: !Z
    - others: not taken
  - Taken: pc_we=1 and pc_sel_br=1, both in the final P4 cycle.
- Writeback (P5):
  - reg_we=1 for ALU ops except CMP, for LD, and for LI (instr[15:11]=5'b10000).
  - reg_we=0 for ST, branches and HLT.
- HLT (instr[15:14]=2'b11, op3=4'b1111): no strobes; after P5 → HALT.
- Simultaneous/boundary cases:
  - run while not in HALT is ignored.
  - run and rst together: reset.
  - A branch in P4 uses the cc value as of the end of P3 of any earlier instruction; it is never updated by the branch itself.
  - Unknown op3: treated as a NOP, with no cc update and no reg_we.
- Total latency: 5+MEM_WAIT cycles per memory instruction; 5 cycles for all others.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - In HALT, step=1 executes exactly one instruction (P1..P5), then returns to HALT.
  - run has priority over step.
  - HLT still ends in HALT.
- When undefined: no step port, and HALT is left only via run.

Decomposition:
- Shared package simple_pkg holds:
  - phase one-hot localparams P1..P5;
  - op3 codes F_ADD..F_MOV and F_HLT=4'b1111;
  - class codes (LD, ST, ALU, BR);
  - branch cond codes;
  - the CC bit indices S=3, Z=2, C=1, V=0.
- One natural sub-module: simple_br_cond. It is purely combinational: inputs cc and cond, output taken.

Test Plan:
- Reset mid-P3 of ADD: assert rst → next cycle phase=0, halted=1, cc=0, no reg_we pulse.
- run; ADD with alu_code=4'b0100: cc=4'b0100 after P3, reg_we=1 in P5 only, total 5 cycles P1→P1.
- CMP with alu_code=4'b1001 then BLT:
  - cc=1001, so S^V=0 → not taken, pc_sel_br=0.
  - Repeat with alu_code=4'b1000 → taken, pc_we=pc_sel_br=1 in P4.
- MEM_WAIT=3, ST: P4 lasts 4 cycles; mem_we is high only in the 4th; no reg_we. LD: mem_re held 4 cycles, reg_we in P5.
- HLT: after P5, halted=1 and phase=0. run re-starts at P1; run asserted during P2 of another instruction has no effect.
- SEQ_SINGLE_STEP_EN: step pulse in HALT → one 5-phase instruction then halted=1; run and step together → continuous run.
